// File: rtl/gpp_run_ctrl.sv
// Run controller for N GPP cores: sequences reset release, counts run cycles, collects Done flags
// and enforces a watchdog. Define GPP_RUN_PERCORE_CYCLES_EN to add per-core Done_Cycles capture.
module gpp_run_ctrl #(
  parameter int unsigned N_CORE     = 1,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic [N_CORE-1:0]      Core_Done,
  output logic [N_CORE-1:0]      Core_Rst,
  output logic                   Busy,
  output logic                   Finished,
  output logic                   Timeout,
  output logic [N_CORE-1:0]      Done_Mask,
`ifdef GPP_RUN_PERCORE_CYCLES_EN
  output logic [N_CORE*CNT_WIDTH-1:0] Done_Cycles,
`endif
  output logic [CNT_WIDTH-1:0]   Cycle_Count
);

  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]        RST_LOAD = RW'(RST_CYCLES - 1);
  localparam logic [RW-1:0]        RST_ONE  = RW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_FINISH, S_TIMEOUT} state_t;

  state_t           state;
  logic [RW-1:0]    rst_cnt;
  logic [N_CORE-1:0] seen;
  logic             done_all;

  always_comb begin
    seen     = Done_Mask | Core_Done;
    done_all = &seen;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      Core_Rst    <= '1;
      Busy        <= 1'b0;
      Finished    <= 1'b0;
      Timeout     <= 1'b0;
      Done_Mask   <= '0;
      Cycle_Count <= '0;
`ifdef GPP_RUN_PERCORE_CYCLES_EN
      Done_Cycles <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_FINISH, S_TIMEOUT: begin
          if (Start) begin
            state       <= S_RESET;
            rst_cnt     <= RST_LOAD;
            Core_Rst    <= '1;
            Busy        <= 1'b1;
            Finished    <= 1'b0;
            Timeout     <= 1'b0;
            Done_Mask   <= '0;
            Cycle_Count <= '0;
`ifdef GPP_RUN_PERCORE_CYCLES_EN
            Done_Cycles <= '0;
`endif
          end
        end
        S_RESET: begin
          if (rst_cnt == '0) begin
            state    <= S_RUN;
            Core_Rst <= '0;
          end else begin
            rst_cnt <= rst_cnt - RST_ONE;
          end
        end
        S_RUN: begin
          Cycle_Count <= Cycle_Count + CNT_ONE;
          Done_Mask   <= seen;
`ifdef GPP_RUN_PERCORE_CYCLES_EN
          for (int i = 0; i < int'(N_CORE); i++) begin
            if (Core_Done[i] && !Done_Mask[i]) begin
              Done_Cycles[i*CNT_WIDTH +: CNT_WIDTH] <= Cycle_Count + CNT_ONE;
            end
          end
`endif
          // Completion takes priority over a watchdog expiring on the same cycle.
          if (done_all) begin
            state    <= S_FINISH;
            Busy     <= 1'b0;
            Finished <= 1'b1;
            Core_Rst <= '1;
          end else if (Cycle_Count == TO_LAST) begin
            state    <= S_TIMEOUT;
            Busy     <= 1'b0;
            Timeout  <= 1'b1;
            Core_Rst <= '1;
          end else begin
            Core_Rst <= seen;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpp_run_ctrl.sv
// Bench for gpp_run_ctrl: directed runs checked against a mode-level model every cycle,
// plus literal expectations at the key points of each scenario.
module tb_gpp_run_ctrl;
  localparam int NC = 4;
  localparam int RC = 2;
  localparam int CW = 16;
  localparam int TO = 20;

  localparam int M_IDLE = 0, M_RST = 1, M_RUN = 2, M_FIN = 3, M_TO = 4;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Start = 1'b0;
  logic [NC-1:0] Core_Done = '0;
  logic [NC-1:0] Core_Rst;
  logic          Busy, Finished, Timeout;
  logic [NC-1:0] Done_Mask;
  logic [CW-1:0] Cycle_Count;
`ifdef GPP_RUN_PERCORE_CYCLES_EN
  logic [NC*CW-1:0] Done_Cycles;
`endif

  int checks = 0;
  int errors = 0;
  bit sim_end = 1'b0;
  int cur = 0;

  gpp_run_ctrl #(
    .N_CORE(NC), .RST_CYCLES(RC), .CNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Core_Done(Core_Done), .Core_Rst(Core_Rst),
    .Busy(Busy), .Finished(Finished), .Timeout(Timeout), .Done_Mask(Done_Mask),
`ifdef GPP_RUN_PERCORE_CYCLES_EN
    .Done_Cycles(Done_Cycles),
`endif
    .Cycle_Count(Cycle_Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: run phase, remaining reset cycles, run cycles elapsed, cores seen done.
  int            m_mode = M_IDLE;
  int            m_left = 0;
  int            m_count = 0;
  logic [NC-1:0] m_mask = '0;
  int            m_dc[NC];

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_mode  <= M_IDLE;
      m_left  <= 0;
      m_count <= 0;
      m_mask  <= '0;
      for (int i = 0; i < NC; i++) m_dc[i] <= 0;
    end else if (m_mode == M_RUN) begin
      m_count <= m_count + 1;
      m_mask  <= m_mask | Core_Done;
      for (int i = 0; i < NC; i++)
        if (Core_Done[i] && !m_mask[i]) m_dc[i] <= m_count + 1;
      if ((m_mask | Core_Done) == {NC{1'b1}}) m_mode <= M_FIN;
      else if (m_count + 1 == TO) m_mode <= M_TO;
    end else if (m_mode == M_RST) begin
      if (m_left == 1) m_mode <= M_RUN;
      m_left <= m_left - 1;
    end else if (Start) begin
      m_mode  <= M_RST;
      m_left  <= RC;
      m_count <= 0;
      m_mask  <= '0;
      for (int i = 0; i < NC; i++) m_dc[i] <= 0;
    end
  end

  always @(negedge Clk) begin
    if (!sim_end) begin
      chk("core_rst", Core_Rst, (m_mode == M_RUN) ? m_mask : {NC{1'b1}});
      chk("busy", Busy, (m_mode == M_RST || m_mode == M_RUN) ? 1'b1 : 1'b0);
      chk("finished", Finished, (m_mode == M_FIN) ? 1'b1 : 1'b0);
      chk("timeout", Timeout, (m_mode == M_TO) ? 1'b1 : 1'b0);
      chk("done_mask", Done_Mask, m_mask);
      chk("cycle_count", Cycle_Count, m_count);
`ifdef GPP_RUN_PERCORE_CYCLES_EN
      for (int i = 0; i < NC; i++)
        chk($sformatf("done_cycles%0d", i), Done_Cycles[i*CW +: CW], m_dc[i]);
`endif
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Called just after a negedge; returns at the negedge inside run cycle 1.
  task automatic start_run();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("rst_hold1", Core_Rst, 4'hF);
    chk("rst_busy", Busy, 1'b1);
    @(negedge Clk);
    chk("rst_hold2", Core_Rst, 4'hF);
    @(negedge Clk);
    chk("rst_release", Core_Rst, 4'h0);
    chk("run_count0", Cycle_Count, 16'd0);
    cur = 1;
  endtask

  task automatic goto_cycle(input int k);
    wait_neg(k - cur);
    cur = k;
  endtask

  task automatic pulse(input logic [NC-1:0] m);
    Core_Done = m;
    @(negedge Clk);
    Core_Done = '0;
    cur = cur + 1;
  endtask

  initial begin
    wait_neg(2);
    chk("por_core_rst", Core_Rst, 4'hF);
    chk("por_busy", Busy, 1'b0);
    chk("por_count", Cycle_Count, 16'd0);
    chk("por_mask", Done_Mask, 4'h0);
    Rst = 1'b0;
    wait_neg(2);

    // All cores done on run cycle 10.
    start_run();
    goto_cycle(10);
    pulse(4'hF);
    chk("t1_finished", Finished, 1'b1);
    chk("t1_count", Cycle_Count, 16'd10);
    chk("t1_mask", Done_Mask, 4'hF);
    chk("t1_core_rst", Core_Rst, 4'hF);

    // Staggered done pulses; Start during run must be ignored.
    start_run();
    goto_cycle(3);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    cur = 4;
    goto_cycle(5);
    pulse(4'b0100);
    chk("t2_freeze_c2", Core_Rst, 4'b0100);
    goto_cycle(7);
    pulse(4'b0001);
    chk("t2_freeze_c0", Core_Rst, 4'b0101);
    goto_cycle(9);
    pulse(4'b1000);
    goto_cycle(12);
    pulse(4'b0010);
    chk("t2_finished", Finished, 1'b1);
    chk("t2_count", Cycle_Count, 16'd12);
    chk("t2_mask", Done_Mask, 4'hF);
`ifdef GPP_RUN_PERCORE_CYCLES_EN
    chk("t2_done_cycles", Done_Cycles, {16'd9, 16'd5, 16'd12, 16'd7});
`endif

    // Watchdog: only core 0 finishes.
    start_run();
    goto_cycle(3);
    pulse(4'b0001);
    goto_cycle(20);
    chk("t3_count19", Cycle_Count, 16'd19);
    @(negedge Clk);
    chk("t3_timeout", Timeout, 1'b1);
    chk("t3_finished", Finished, 1'b0);
    chk("t3_count", Cycle_Count, 16'd20);
    chk("t3_mask", Done_Mask, 4'b0001);
`ifdef GPP_RUN_PERCORE_CYCLES_EN
    chk("t3_done_cycles", Done_Cycles, {16'd0, 16'd0, 16'd0, 16'd3});
`endif

    // Completion on the watchdog cycle wins.
    start_run();
    goto_cycle(2);
    pulse(4'b0111);
    goto_cycle(20);
    pulse(4'b1000);
    chk("t4_finished", Finished, 1'b1);
    chk("t4_timeout", Timeout, 1'b0);
    chk("t4_count", Cycle_Count, 16'd20);

    // Asynchronous reset mid-run.
    start_run();
    goto_cycle(4);
    pulse(4'b0001);
    goto_cycle(6);
    #2 Rst = 1'b1;
    #1;
    chk("t6_busy", Busy, 1'b0);
    chk("t6_core_rst", Core_Rst, 4'hF);
    chk("t6_count", Cycle_Count, 16'd0);
    chk("t6_mask", Done_Mask, 4'h0);
    wait_neg(2);
    Rst = 1'b0;
    // Done held across Start and reset is sampled on run cycle 1.
    Core_Done = 4'hF;
    wait_neg(1);
    start_run();
    @(negedge Clk);
    Core_Done = '0;
    chk("t6_early_finished", Finished, 1'b1);
    chk("t6_early_count", Cycle_Count, 16'd1);
    start_run();
    goto_cycle(3);
    pulse(4'hF);
    chk("t6_clean_count", Cycle_Count, 16'd3);
    chk("t6_clean_mask", Done_Mask, 4'hF);

    wait_neg(1);
    sim_end = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpp_run_ctrl.md
Name: gpp_run_ctrl

Overview:
Synthesisable run controller for N GPP cores sharing one clock. It sequences core reset release, counts run cycles and collects each core's Done flag. It enforces a watchdog timeout and reports a final pass or timeout status. It sits between the top-level reset/start source and the cores' Rst inputs, and replaces ad-hoc wait-for-Done sequencing.

Parameters:
N_CORE, 1, number of GPP cores controlled (1..16)
RST_CYCLES, 2, cycles core reset is held after Start (>=1)
CNT_WIDTH, 32, width of cycle counter
TIMEOUT, 100000, run cycles allowed before watchdog fires (>=1, < 2^CNT_WIDTH)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-high reset
Start  input  1  single-cycle pulse; launches a run when not Busy
Core_Done  input  N_CORE  per-core Done flag (level or pulse)
Core_Rst  output  N_CORE  per-core reset, active-high
Busy  output  1  high in S_RESET and S_RUN
Finished  output  1  high in S_FINISH (all cores done)
Timeout  output  1  high in S_TIMEOUT
Done_Mask  output  N_CORE  sticky per-core done record
Cycle_Count  output  CNT_WIDTH  run cycles elapsed in S_RUN

Behaviour:
- Reset (async, Rst=1): state S_IDLE; Core_Rst all 1; Busy, Finished and Timeout 0; Done_Mask 0; Cycle_Count 0; internal reset counter 0.
- All outputs are registered. State is encoded S_IDLE, S_RESET, S_RUN, S_FINISH, S_TIMEOUT.
- S_IDLE: Core_Rst all 1. Start=1 -> S_RESET. On the same edge: Cycle_Count<=0, Done_Mask<=0, reset counter<=RST_CYCLES-1.
- S_RESET: Core_Rst all 1, Busy=1. Reset counter decrements each cycle. When it is 0 -> S_RUN, and Core_Rst goes 0 on that edge. Core_Rst is therefore high for exactly RST_CYCLES cycles after the Start edge.
- S_RUN: Busy=1. Cycle_Count increments by 1 every cycle.
  - Done_Mask <= Done_Mask | Core_Done.
  - Core_Rst[i] <= Done_Mask[i] | Core_Done[i], so a core that has finished is frozen in reset from the next cycle.
- Completion: if (Done_Mask | Core_Done) is all ones -> S_FINISH on that edge.
- Watchdog: if Cycle_Count == TIMEOUT-1 and not all done -> S_TIMEOUT.
- Completion and watchdog on the same cycle: S_FINISH wins.
- Cycle_Count stops at the last S_RUN value: no increment in S_FINISH or S_TIMEOUT.
- S_FINISH: Finished=1, Busy=0, Core_Rst all 1. Done_Mask and Cycle_Count are held.
- S_TIMEOUT: Timeout=1, Busy=0, Core_Rst all 1. Done_Mask shows the cores that did finish; Cycle_Count=TIMEOUT.
- S_FINISH/S_TIMEOUT + Start=1 -> S_RESET, with the same initialisation as from S_IDLE.
- Start while Busy is ignored, with no effect on the counters.
- Core_Done is ignored outside S_RUN. A Done already high at S_RESET->S_RUN is sampled on the first S_RUN cycle.
- Rst asserted mid-run: immediate return to the reset values; the run is abandoned.
- Cycle_Count never wraps; this is guaranteed by the TIMEOUT bound.

Optional Feature:
GPP_RUN_PERCORE_CYCLES_EN
- Defined: adds output Done_Cycles (N_CORE*CNT_WIDTH), with core i in bits [i*CNT_WIDTH +: CNT_WIDTH].
  - Captures Cycle_Count+1 on the first cycle Core_Done[i] is seen in S_RUN. Later Done pulses do not overwrite it.
  - Cleared to 0 on reset and on run start.
  - Remains 0 for cores that never finish.
- Undefined: port and registers are absent; all other behaviour is identical.

Test Plan:
1. N_CORE=1, RST_CYCLES=2: Rst 1->0, Start pulse, Core_Done rises on the 10th S_RUN cycle -> Core_Rst high 2 cycles after Start then low; Finished=1 next edge; Cycle_Count=10; Done_Mask=1; Core_Rst=1.
2. N_CORE=4: Done pulses on cores 2,0,3,1 at run cycles 5,7,9,12 -> each Core_Rst[i] rises the cycle after its pulse; Finished after cycle 12; Done_Mask=4'hF. With GPP_RUN_PERCORE_CYCLES_EN, Done_Cycles = {12,9,5,7} for cores 1,3,2,0.
3. TIMEOUT=20, N_CORE=2, only core 0 done at cycle 3 -> Timeout=1 after 20 run cycles; Cycle_Count=20; Done_Mask=2'b01; Finished=0.
4. TIMEOUT=20, last core Done on run cycle 20 -> Finished=1, Timeout=0 (priority rule).
5. Start pulsed during S_RUN -> ignored, with Cycle_Count continuous. Start in S_FINISH -> new run, Cycle_Count and Done_Mask cleared, Core_Rst high for RST_CYCLES.
6. Rst asserted asynchronously mid-S_RUN (between edges) -> outputs immediately return to reset values; Start after release begins a clean run.
